// File: rtl/mem_map_ctrl.sv
// System-bus memory-map controller: base/mask region decode, one-hot slave select held
// through a request/ack handshake, ack timeout watchdog and a sticky first-fault register.
module mem_map_ctrl #(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned NUM_REGIONS = 4,
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
      {32'hFFFF_F800, 32'hFFFF_F000, 32'h1000_0000, 32'h0000_0000},
   parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
      {32'hFFFF_F800, 32'hFFFF_F800, 32'hFFFF_0000, 32'hFFFF_0000},
   parameter int unsigned TIMEOUT_CYC = 16
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   sys_req,
   input  logic [ADDR_W-1:0]      sys_address,
   output logic                   sys_ready,
   output logic [NUM_REGIONS-1:0] en_mem,
   input  logic [NUM_REGIONS-1:0] slv_ack,
   output logic                   rsp_valid,
   output logic                   rsp_err,
   output logic                   fault_valid,
   output logic [ADDR_W-1:0]      fault_addr,
   output logic [1:0]             fault_code,
   output logic                   fault_ovf,
   input  logic                   fault_clr
);

   localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [1:0]  CODE_UNMAPPED = 2'b01;
   localparam logic [1:0]  CODE_TIMEOUT  = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic [NUM_REGIONS-1:0] hit_vec;
   logic                   any_hit, ack_sel, timeout_hit;

   logic                   ready_d, rsp_valid_d, rsp_err_d;
   logic [NUM_REGIONS-1:0] en_mem_d;
   logic                   flt_new;
   logic [1:0]             flt_new_code;
   logic [ADDR_W-1:0]      flt_new_addr;
   logic                   fault_valid_d, fault_ovf_d;
   logic [1:0]             fault_code_d;
   logic [ADDR_W-1:0]      fault_addr_d;

   // Priority decode: walking downwards lets the lowest matching index win.
   always_comb begin
      hit_vec = '0;
      for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
         if ((sys_address & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W])
            hit_vec = NUM_REGIONS'(1) << i;
      end
   end

   assign any_hit     = |hit_vec;
   assign ack_sel     = |(slv_ack & en_mem);
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (sys_req) state_d = any_hit ? ST_ACCESS : ST_RESP;
         ST_ACCESS: if (ack_sel || timeout_hit) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Next values for every registered output and the datapath.
   always_comb begin
      ready_d      = (state_d == ST_IDLE);
      rsp_valid_d  = (state_d == ST_RESP);
      rsp_err_d    = 1'b0;
      en_mem_d     = '0;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      flt_new      = 1'b0;
      flt_new_code = 2'b00;
      flt_new_addr = '0;
      case (state_q)
         ST_IDLE: begin
            if (sys_req) begin
               addr_d = sys_address;
               cnt_d  = '0;
               if (any_hit) begin
                  en_mem_d = hit_vec;
               end else begin
                  rsp_err_d    = 1'b1;
                  flt_new      = 1'b1;
                  flt_new_code = CODE_UNMAPPED;
                  flt_new_addr = sys_address;
               end
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!ack_sel) begin
               if (timeout_hit) begin
                  rsp_err_d    = 1'b1;
                  flt_new      = 1'b1;
                  flt_new_code = CODE_TIMEOUT;
                  flt_new_addr = addr_q;
               end else begin
                  en_mem_d = en_mem;
               end
            end
         end
         default: ;
      endcase

      fault_valid_d = fault_valid;
      fault_addr_d  = fault_addr;
      fault_code_d  = fault_code;
      fault_ovf_d   = fault_ovf;
      // A clear in the same cycle as a new fault makes room for that fault.
      if (flt_new) begin
         if (!fault_valid || fault_clr) begin
            fault_valid_d = 1'b1;
            fault_addr_d  = flt_new_addr;
            fault_code_d  = flt_new_code;
            fault_ovf_d   = 1'b0;
         end else begin
            fault_ovf_d = 1'b1;
         end
      end else if (fault_clr) begin
         fault_valid_d = 1'b0;
         fault_code_d  = 2'b00;
         fault_ovf_d   = 1'b0;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         sys_ready   <= 1'b1;
         en_mem      <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         cnt_q       <= '0;
         addr_q      <= '0;
         fault_valid <= 1'b0;
         fault_addr  <= '0;
         fault_code  <= 2'b00;
         fault_ovf   <= 1'b0;
      end else begin
         sys_ready   <= ready_d;
         en_mem      <= en_mem_d;
         rsp_valid   <= rsp_valid_d;
         rsp_err     <= rsp_err_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         fault_valid <= fault_valid_d;
         fault_addr  <= fault_addr_d;
         fault_code  <= fault_code_d;
         fault_ovf   <= fault_ovf_d;
      end
   end

endmodule

// File: tb/tb_mem_map_ctrl.sv
// Directed bench for mem_map_ctrl: decode, handshake latency, timeout, fault register, reset abort.
module tb_mem_map_ctrl;

   logic        sys_clk = 1'b0;
   logic        sys_rst;
   logic        sys_req;
   logic [31:0] sys_address;
   logic        sys_ready;
   logic [3:0]  en_mem;
   logic [3:0]  slv_ack;
   logic        rsp_valid;
   logic        rsp_err;
   logic        fault_valid;
   logic [31:0] fault_addr;
   logic [1:0]  fault_code;
   logic        fault_ovf;
   logic        fault_clr;

   int errors = 0;
   int checks = 0;

   mem_map_ctrl dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .sys_req    (sys_req),
      .sys_address(sys_address),
      .sys_ready  (sys_ready),
      .en_mem     (en_mem),
      .slv_ack    (slv_ack),
      .rsp_valid  (rsp_valid),
      .rsp_err    (rsp_err),
      .fault_valid(fault_valid),
      .fault_addr (fault_addr),
      .fault_code (fault_code),
      .fault_ovf  (fault_ovf),
      .fault_clr  (fault_clr)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic issue(input logic [31:0] addr);
      sys_req     = 1'b1;
      sys_address = addr;
      step();
      sys_req     = 1'b0;
   endtask

   initial begin
      sys_rst = 1'b1; sys_req = 1'b0; sys_address = '0; slv_ack = '0; fault_clr = 1'b0;
      step(); step();
      check("rst_ready",  32'(sys_ready),   32'd1);
      check("rst_en_mem", 32'(en_mem),      32'd0);
      check("rst_rsp",    32'({rsp_valid, rsp_err}), 32'd0);
      check("rst_fault",  32'({fault_valid, fault_code, fault_ovf}), 32'd0);
      check("rst_faddr",  fault_addr,       32'd0);
      sys_rst = 1'b0;
      step();

      // Region 0 hit, ack in first ACCESS cycle
      issue(32'h0000_0010);
      check("r0_en_mem", 32'(en_mem),    32'h1);
      check("r0_ready",  32'(sys_ready), 32'd0);
      check("r0_norsp",  32'(rsp_valid), 32'd0);
      slv_ack = 4'b0001;
      step();
      slv_ack = 4'b0000;
      check("r0_rsp",    32'({rsp_valid, rsp_err}), 32'b10);
      check("r0_en_off", 32'(en_mem), 32'd0);
      step();
      check("r0_rspdone", 32'(rsp_valid), 32'd0);
      check("r0_ready2",  32'(sys_ready), 32'd1);

      // Regions 3 and 2 at their shared boundary
      issue(32'hFFFF_F800);
      check("r3_en_mem", 32'(en_mem), 32'h8);
      slv_ack = 4'b1000; step(); slv_ack = 4'b0000;
      check("r3_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
      step();
      issue(32'hFFFF_F7FC);
      check("r2_en_mem", 32'(en_mem), 32'h4);
      slv_ack = 4'b0100; step(); slv_ack = 4'b0000;
      check("r2_rsp", 32'({rsp_valid, rsp_err}), 32'b10);
      step();

      // Unmapped access
      issue(32'h2000_0000);
      check("miss_en_mem", 32'(en_mem), 32'd0);
      check("miss_rsp",    32'({rsp_valid, rsp_err}), 32'b11);
      check("miss_fvalid", 32'(fault_valid), 32'd1);
      check("miss_faddr",  fault_addr, 32'h2000_0000);
      check("miss_fcode",  32'(fault_code), 32'h1);
      check("miss_fovf",   32'(fault_ovf), 32'd0);
      step();
      fault_clr = 1'b1; step(); fault_clr = 1'b0;
      check("clr_fault", 32'({fault_valid, fault_code, fault_ovf}), 32'd0);

      // Timeout on region 1, then a second timeout sets overflow only
      issue(32'h1000_0004);
      check("to_en_mem", 32'(en_mem), 32'h2);
      for (int i = 0; i < 15; i++) step();
      check("to_c16_norsp", 32'(rsp_valid), 32'd0);
      check("to_c16_en",    32'(en_mem), 32'h2);
      step();
      check("to_rsp",    32'({rsp_valid, rsp_err}), 32'b11);
      check("to_fvalid", 32'(fault_valid), 32'd1);
      check("to_fcode",  32'(fault_code), 32'h2);
      check("to_faddr",  fault_addr, 32'h1000_0004);
      step();
      issue(32'h1000_0008);
      for (int i = 0; i < 16; i++) step();
      check("to2_rsp",   32'({rsp_valid, rsp_err}), 32'b11);
      check("to2_fovf",  32'(fault_ovf), 32'd1);
      check("to2_faddr", fault_addr, 32'h1000_0004);
      check("to2_fcode", 32'(fault_code), 32'h2);
      step();
      fault_clr = 1'b1; step(); fault_clr = 1'b0;

      // Ack on the 16th ACCESS cycle wins; requests during ACCESS are ignored
      issue(32'h1000_0004);
      sys_req = 1'b1; sys_address = 32'h2000_0000;
      for (int i = 0; i < 15; i++) step();
      sys_req = 1'b0;
      slv_ack = 4'b0010; step(); slv_ack = 4'b0000;
      check("ack16_rsp",    32'({rsp_valid, rsp_err}), 32'b10);
      check("ack16_nofault", 32'(fault_valid), 32'd0);
      step();

      // Wrong-slave ack is ignored and the access times out
      issue(32'h1000_0004);
      slv_ack = 4'b0100;
      for (int i = 0; i < 16; i++) step();
      slv_ack = 4'b0000;
      check("wrong_rsp",   32'({rsp_valid, rsp_err}), 32'b11);
      check("wrong_fcode", 32'(fault_code), 32'h2);
      step();

      // Miss while a fault is held -> overflow; clear together with a miss -> fresh capture
      issue(32'h2000_0000);
      check("ovf_miss", 32'(fault_ovf), 32'd1);
      check("ovf_keep", fault_addr, 32'h1000_0004);
      step();
      fault_clr = 1'b1;
      issue(32'h3000_0000);
      fault_clr = 1'b0;
      check("clrmiss_fvalid", 32'(fault_valid), 32'd1);
      check("clrmiss_fovf",   32'(fault_ovf), 32'd0);
      check("clrmiss_faddr",  fault_addr, 32'h3000_0000);
      check("clrmiss_fcode",  32'(fault_code), 32'h1);
      step();

      // Reset in ACCESS cycle 3 aborts immediately
      issue(32'h0000_0010);
      step(); step();
      check("abort_pre_en", 32'(en_mem), 32'h1);
      sys_rst = 1'b1;
      #1;
      check("abort_en_mem", 32'(en_mem), 32'd0);
      check("abort_rsp",    32'(rsp_valid), 32'd0);
      step();
      sys_rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      check("abort_ready", 32'(sys_ready), 32'd1);
      check("abort_fault", 32'(fault_valid), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
